seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
// - Serial frame transmitter; the sending end of the serial sequence-detector link.
// - Accepts a parallel word over a valid/ready handshake and emits it on a 1-bit line.
// - Frame format: SYNC pattern first, then the data word MSB-first.
// - The downstream detector locks onto SYNC, so the line idles high (an idle 1 never advances the detector).
// PARAMETERS
// - DATA_W  8        payload width in bits; legal range 1..32
// - SYNC_W  4        sync pattern width in bits; legal range 2..8
// - SYNC    4'b0110  sync pattern, sent MSB-first; matches the detector's target sequence
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous active-low reset
// - load_valid  in   1       load_data is valid
// - load_data   in   DATA_W  word to transmit; captured on handshake
// - load_ready  out  1       high only in IDLE; transfer occurs when load_valid && load_ready at a clk edge
// - out         out  1       serial line; 1 when idle
// - out_valid   out  1       high while out carries a frame bit (sync, data or parity)
// - busy        out  1       high from the cycle after acceptance until the frame ends
// - done        out  1       single-cycle pulse in the cycle after the last frame bit
// BEHAVIOUR
// - Reset values: out=1, out_valid=0, busy=0, done=0, load_ready=1; FSM=IDLE; shift register and counter cleared.
// - All outputs are registered. The FSM has states IDLE, SYNC, DATA and (if configured) PAR.
// - IDLE:
//   - On handshake, latch load_data into a DATA_W-bit shift register and load SYNC into the sync shifter.
//   - Go to SYNC.
// - SYNC: lasts SYNC_W cycles.
//   - out = SYNC[SYNC_W-1-k] in cycle k.
//   - Go to DATA after the last sync bit.
// - DATA: lasts DATA_W cycles.
//   - out = latched word MSB-first, i.e. bit DATA_W-1 first.
//   - After the last bit, go to PAR if enabled, otherwise to IDLE.
// - PAR: lasts 1 cycle; out = even parity (XOR of the latched word). Then go to IDLE.
// - Latency:
//   - The first sync bit appears on out in the cycle immediately after the accepting edge.
//   - The frame lasts SYNC_W+DATA_W(+1) cycles.
// - done:
//   - Asserted for 1 cycle together with the return to IDLE, while out=1 and out_valid=0.
//   - load_ready is also 1 in that cycle, so the minimum gap between frames is 1 idle cycle.
// - While busy:
//   - load_valid is ignored and load_data is not sampled.
//   - The word latched at acceptance is what gets sent, even if load_data changes afterwards.
// - Bit counter: $clog2(max(DATA_W,SYNC_W))+1 bits wide. It reloads at each state entry and never wraps within a state.
// - Reset mid-frame: the frame is aborted immediately (asynchronously); out returns to 1; no done pulse.
// - load_valid held high continuously: frames are sent back-to-back, each separated by exactly 1 idle cycle.
// - Payload bits may alias SYNC; this is permitted. Framing and deduplication are the receiver's concern.
// CONFIGURATION
// - SEQ_PATTERN_TX_PARITY_EN defined:
//   - PAR state present; one even-parity bit follows the data.
//   - Frame length is SYNC_W+DATA_W+1.
// - SEQ_PATTERN_TX_PARITY_EN undefined:
//   - No PAR state and no parity logic.
//   - Frame length is SYNC_W+DATA_W; DATA goes straight to IDLE.
// TESTING
// - Reset: hold rst_n=0 for 3 clk, release -> out=1, out_valid=0, busy=0, done=0, load_ready=1.
// - Single frame, parity off: load 8'hA5 at edge 0.
//   - out over cycles 1..12 = 0,1,1,0, 1,0,1,0,0,1,0,1 with out_valid=1.
//   - done=1 and out=1 in cycle 13.
// - Parity on: load 8'h07 -> 12 bits as above for the payload, then parity bit 1 in cycle 13, done in cycle 14.
//   Load 8'hA5 -> parity bit 0.
// - Busy ignore: accept 8'h3C; at cycle 5 drive load_valid=1 with load_data=8'hFF.
//   - Payload sent is still 0,0,1,1,1,1,0,0.
//   - 8'hFF is accepted only in the done/idle cycle.
// - Back-to-back: hold load_valid=1 with 8'h81 then 8'h18.
//   - Second sync starts exactly 1 cycle after the first done.
//   - Total gap of out_valid=0 is 1 cycle.
// - Async abort: assert rst_n=0 mid-DATA (cycle 7, between edges) -> out=1 and busy=0 immediately; no done pulse.
//   - Next frame after release transmits correctly.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial line bundle for seq_pattern_tx.
// master = word producer side, slave = the transmitter.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (
    output load_valid, load_data,
    input  load_ready, out, out_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: SYNC pattern then data word MSB-first on a line that idles high.
// Define SEQ_PATTERN_TX_PARITY_EN to append one even-parity bit after the data.
module seq_pattern_tx #(
  parameter int              DATA_W = 8,
  parameter int              SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC = 4'b0110
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_pattern_tx_if.slave  link
);

  localparam int MAX_W = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;

`ifdef SEQ_PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] dataSh;
  logic [SYNC_W-1:0] syncSh;
  logic [CNT_W-1:0]  bitCnt;
  logic              outReg;
  logic              outValidReg;
  logic              busyReg;
  logic              doneReg;
  logic              readyReg;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic              parBit;
`endif

  // bitCnt holds the number of bits still to send in the current state after the one on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dataSh      <= '0;
      syncSh      <= '0;
      bitCnt      <= '0;
      outReg      <= 1'b1;
      outValidReg <= 1'b0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      readyReg    <= 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      parBit      <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          outReg      <= 1'b1;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
          readyReg    <= 1'b1;
          if (link.load_valid) begin
            state       <= ST_SYNC;
            dataSh      <= link.load_data;
            syncSh      <= SYNC << 1;
            bitCnt      <= CNT_W'(SYNC_W - 1);
            outReg      <= SYNC[SYNC_W-1];
            outValidReg <= 1'b1;
            busyReg     <= 1'b1;
            readyReg    <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            parBit      <= ^link.load_data;
`endif
          end
        end

        ST_SYNC: begin
          if (bitCnt == '0) begin
            state  <= ST_DATA;
            outReg <= dataSh[DATA_W-1];
            dataSh <= dataSh << 1;
            bitCnt <= CNT_W'(DATA_W - 1);
          end else begin
            outReg <= syncSh[SYNC_W-1];
            syncSh <= syncSh << 1;
            bitCnt <= bitCnt - 1'b1;
          end
        end

        ST_DATA: begin
          if (bitCnt == '0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
            state  <= ST_PAR;
            outReg <= parBit;
`else
            state       <= ST_IDLE;
            outReg      <= 1'b1;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b1;
            readyReg    <= 1'b1;
`endif
          end else begin
            outReg <= dataSh[DATA_W-1];
            dataSh <= dataSh << 1;
            bitCnt <= bitCnt - 1'b1;
          end
        end

`ifdef SEQ_PATTERN_TX_PARITY_EN
        ST_PAR: begin
          state       <= ST_IDLE;
          outReg      <= 1'b1;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
          doneReg     <= 1'b1;
          readyReg    <= 1'b1;
        end
`endif

        default: begin
          state       <= ST_IDLE;
          outReg      <= 1'b1;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
          readyReg    <= 1'b1;
        end
      endcase
    end
  end

  assign link.out        = outReg;
  assign link.out_valid  = outValidReg;
  assign link.busy       = busyReg;
  assign link.done       = doneReg;
  assign link.load_ready = readyReg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: queue-based frame model plus literal frame checks.
// Build with SEQ_PATTERN_TX_PARITY_EN defined to exercise the parity variant.
module tb_seq_pattern_tx;

  localparam int          DATA_W = 8;
  localparam int          SYNC_W = 4;
  localparam logic [3:0]  SYNC   = 4'b0110;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int          FRAME_LEN = SYNC_W + DATA_W + 1;
`else
  localparam int          FRAME_LEN = SYNC_W + DATA_W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic checkEn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  seq_pattern_tx_if #(.DATA_W(DATA_W)) link();

  seq_pattern_tx #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is just a queue of bits; the done cycle follows the last one.
  bit   mq[$];
  logic mOut = 1'b1, mValid = 1'b0, mBusy = 1'b0, mDone = 1'b0, mReady = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mOut = 1'b1; mValid = 1'b0; mBusy = 1'b0; mDone = 1'b0; mReady = 1'b1;
    end else begin
      mDone = 1'b0;
      if (mReady && link.load_valid) begin
        for (int i = SYNC_W - 1; i >= 0; i--) mq.push_back(SYNC[i]);
        for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(link.load_data[i]);
`ifdef SEQ_PATTERN_TX_PARITY_EN
        mq.push_back(^link.load_data);
`endif
      end
      if (mq.size() > 0) begin
        mOut = mq.pop_front(); mValid = 1'b1; mBusy = 1'b1; mReady = 1'b0;
      end else if (mBusy) begin
        mOut = 1'b1; mValid = 1'b0; mBusy = 1'b0; mReady = 1'b1; mDone = 1'b1;
      end else begin
        mOut = 1'b1; mValid = 1'b0; mReady = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_out",        32'(link.out),        32'(mOut));
      checkOutput("model_out_valid",  32'(link.out_valid),  32'(mValid));
      checkOutput("model_busy",       32'(link.busy),       32'(mBusy));
      checkOutput("model_done",       32'(link.done),       32'(mDone));
      checkOutput("model_load_ready", 32'(link.load_ready), 32'(mReady));
    end
  end

  // Observes one frame starting in cycle 1 after the accepting edge; optionally injects a new load.
  task automatic applyStimulus(input bit holdValid, input int injectAt, input logic [7:0] injectData,
                               output logic [15:0] bits, output int nBits,
                               output int doneAt, output int firstValidAt);
    bits = '0; nBits = 0; doneAt = -1; firstValidAt = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1 && !holdValid) link.load_valid = 1'b0;
      if (k == injectAt) begin
        link.load_valid = 1'b1;
        link.load_data  = injectData;
      end
      if (link.out_valid) begin
        if (firstValidAt < 0) firstValidAt = k;
        bits = {bits[14:0], link.out};
        nBits++;
      end
      if (link.done) begin
        doneAt = k;
        checkOutput("done_line_idle", 32'(link.out), 32'd1);
        break;
      end
    end
    if (doneAt < 0) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic startLoad(input logic [7:0] data);
    @(negedge clk);
    link.load_valid = 1'b1;
    link.load_data  = data;
  endtask

  logic [15:0] bits;
  int          nBits, doneAt, firstAt;
  logic [15:0] expA5, exp07, expFF;

  initial begin
    link.load_valid = 1'b0;
    link.load_data  = '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    expA5 = 16'b0000_0110_1010_0101_0 >> 0;
    expA5 = {3'b000, 12'b0110_1010_0101, 1'b0};
    exp07 = {3'b000, 12'b0110_0000_0111, 1'b1};
    expFF = {3'b000, 12'b0110_1111_1111, 1'b0};
`else
    expA5 = {4'b0000, 12'b0110_1010_0101};
    exp07 = {4'b0000, 12'b0110_0000_0111};
    expFF = {4'b0000, 12'b0110_1111_1111};
`endif

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_out",        32'(link.out),        32'd1);
    checkOutput("reset_out_valid",  32'(link.out_valid),  32'd0);
    checkOutput("reset_busy",       32'(link.busy),       32'd0);
    checkOutput("reset_done",       32'(link.done),       32'd0);
    checkOutput("reset_load_ready", 32'(link.load_ready), 32'd1);

    $display("[TB] single frame 0xA5");
    startLoad(8'hA5);
    applyStimulus(1'b0, 0, 8'h00, bits, nBits, doneAt, firstAt);
    checkOutput("a5_bits",   32'(bits),   32'(expA5));
    checkOutput("a5_nbits",  32'(nBits),  32'(FRAME_LEN));
    checkOutput("a5_doneat", 32'(doneAt), 32'(FRAME_LEN + 1));
    checkOutput("a5_first",  32'(firstAt), 32'd1);

    $display("[TB] single frame 0x07");
    startLoad(8'h07);
    applyStimulus(1'b0, 0, 8'h00, bits, nBits, doneAt, firstAt);
    checkOutput("h07_bits",   32'(bits),   32'(exp07));
    checkOutput("h07_doneat", 32'(doneAt), 32'(FRAME_LEN + 1));

    $display("[TB] load ignored while busy");
    startLoad(8'h3C);
    applyStimulus(1'b0, 5, 8'hFF, bits, nBits, doneAt, firstAt);
    checkOutput("busy_payload", 32'((bits >> (FRAME_LEN - SYNC_W - DATA_W)) & 16'h00FF), 32'h3C);
    applyStimulus(1'b0, 0, 8'h00, bits, nBits, doneAt, firstAt);
    checkOutput("busy_ff_first", 32'(firstAt), 32'd1);
    checkOutput("busy_ff_bits",  32'(bits),    32'(expFF));

    $display("[TB] back-to-back 0x81 then 0x18");
    startLoad(8'h81);
    applyStimulus(1'b1, 2, 8'h18, bits, nBits, doneAt, firstAt);
    checkOutput("b2b_first_payload", 32'((bits >> (FRAME_LEN - SYNC_W - DATA_W)) & 16'h00FF), 32'h81);
    applyStimulus(1'b0, 0, 8'h00, bits, nBits, doneAt, firstAt);
    checkOutput("b2b_gap", 32'(firstAt), 32'd1);
    checkOutput("b2b_second_payload", 32'((bits >> (FRAME_LEN - SYNC_W - DATA_W)) & 16'h00FF), 32'h18);

    $display("[TB] asynchronous abort mid-data");
    startLoad(8'hA5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) link.load_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_out",       32'(link.out),       32'd1);
    checkOutput("abort_busy",      32'(link.busy),      32'd0);
    checkOutput("abort_out_valid", 32'(link.out_valid), 32'd0);
    checkOutput("abort_done",      32'(link.done),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startLoad(8'hA5);
    applyStimulus(1'b0, 0, 8'h00, bits, nBits, doneAt, firstAt);
    checkOutput("post_abort_bits", 32'(bits), 32'(expA5));

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      link.load_valid = ($urandom_range(0, 3) != 0);
      link.load_data  = 8'($urandom);
    end
    @(negedge clk);
    link.load_valid = 1'b0;
    repeat (FRAME_LEN + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
